// File: rtl/mem_ring_stop.sv
// mem_ring_stop: memory-side stop on the main ring.
// Absorbs Address/WriteData slots from the caches and queues line requests in arrival order.
// Issues them to a line-burst memory port and returns read words on the read-return ring.
module mem_ring_stop #(
  parameter int unsigned CMD_DEPTH = 16,
  parameter int unsigned WLINES    = 16,
  parameter logic [3:0]  NULL_DEST = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SourceOut,
  output logic [31:0] RDreturn,
  output logic [3:0]  RDdest,
  output logic        memCmdValid,
  input  logic        memCmdReady,
  output logic        memCmdWrite,
  output logic [27:0] memAddr,
  output logic [31:0] memWData,
  output logic        memWDataValid,
  input  logic        memWDataReady,
  input  logic [31:0] memRData,
  input  logic        memRDataValid,
  output logic        protoErr
);
  localparam int unsigned WDEPTH   = 8 * WLINES;
  localparam int unsigned CAW      = $clog2(CMD_DEPTH);
  localparam int unsigned WAW      = $clog2(WDEPTH);
  localparam logic [CAW:0] CMD_FULL = (CAW+1)'(CMD_DEPTH);
  localparam logic [WAW:0] WD_FULL  = (WAW+1)'(WDEPTH);
  localparam logic [3:0] SLOT_NULL  = 4'd7;
  localparam logic [3:0] SLOT_ADDR  = 4'd2;
  localparam logic [3:0] SLOT_WDATA = 4'd3;

  typedef enum logic [1:0] {CMD_IDLE = 2'd0, CMD_ISSUE = 2'd1, CMD_WDATA = 2'd2} cmd_state_e;

  cmd_state_e  state_q, state_d;
  logic [31:0] ring_out_q, ring_out_d, rd_return_q, rd_return_d;
  logic [3:0]  slot_type_out_q, slot_type_out_d, source_out_q, source_out_d;
  logic [3:0]  rd_dest_q, rd_dest_d, stg_cnt_q, stg_cnt_d;
  logic        proto_err_q, proto_err_d;
  logic [2:0]  wcnt_q, wcnt_d, rcnt_q, rcnt_d;

  // Command FIFO entries are {write, line address, source}.
  logic [32:0]    cmd_mem_q [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CAW:0]   cmd_cnt_q, cmd_cnt_d;
  logic [31:0]    wd_mem_q [WDEPTH];
  logic [WAW:0]   wd_wr_q, wd_wr_d, wd_commit_q, wd_commit_d, wd_cnt_q, wd_cnt_d;
  logic [WAW-1:0] wd_rd_q, wd_rd_d;
  logic [3:0]     tag_mem_q [CMD_DEPTH];
  logic [CAW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CAW:0]   tag_cnt_q, tag_cnt_d;

  logic        slot_wdata_s, slot_addr_s, addr_read_s, wr_addr_s, discard_s;
  logic        cmd_push_req_s, cmd_push_s, cmd_pop_s, wd_push_s, wd_pop_s;
  logic        tag_push_s, tag_pop_s, rd_orphan_s, mem_cmd_valid_s;
  logic [WAW:0] wd_staged_s;
  logic [32:0] cmd_head_s;
  logic        unused_ok_s;

  // The I/D flag is carried by the caches but has no meaning at the memory side.
  assign unused_ok_s = ^{RingIn[29]};
  assign cmd_head_s  = cmd_mem_q[cmd_rd_q];

  // Decode the incoming slot and decide which pushes are accepted this cycle.
  always_comb begin
    slot_wdata_s   = (SlotTypeIn == SLOT_WDATA);
    slot_addr_s    = (SlotTypeIn == SLOT_ADDR) && (RingIn[31:30] == 2'b00);
    addr_read_s    = RingIn[28];
    wr_addr_s      = slot_addr_s && !addr_read_s;
    cmd_push_req_s = slot_addr_s && (addr_read_s || (stg_cnt_q == 4'd8));
    cmd_push_s     = cmd_push_req_s && ((cmd_cnt_q != CMD_FULL) || cmd_pop_s);
    wd_push_s      = slot_wdata_s && ((wd_cnt_q != WD_FULL) || wd_pop_s);
    discard_s      = wr_addr_s && !cmd_push_s;
    wd_staged_s    = wd_wr_q - wd_commit_q;
  end

  // Ring stage: consumed slots leave as Null, everything else is delayed one cycle.
  always_comb begin
    if (slot_wdata_s || slot_addr_s) begin
      ring_out_d      = 32'd0;
      slot_type_out_d = SLOT_NULL;
    end else begin
      ring_out_d      = RingIn;
      slot_type_out_d = SlotTypeIn;
    end
    source_out_d = SourceIn;
  end

  // FIFO pointers and counts; a rejected write line rewinds the write-data FIFO to the last commit point.
  always_comb begin
    cmd_wr_d  = cmd_wr_q + CAW'(cmd_push_s);
    cmd_rd_d  = cmd_rd_q + CAW'(cmd_pop_s);
    cmd_cnt_d = cmd_cnt_q + (CAW+1)'(cmd_push_s) - (CAW+1)'(cmd_pop_s);
    tag_wr_d  = tag_wr_q + CAW'(tag_push_s);
    tag_rd_d  = tag_rd_q + CAW'(tag_pop_s);
    tag_cnt_d = tag_cnt_q + (CAW+1)'(tag_push_s) - (CAW+1)'(tag_pop_s);
    wd_rd_d   = wd_rd_q + WAW'(wd_pop_s);
    if (discard_s) begin
      wd_wr_d  = wd_commit_q;
      wd_cnt_d = wd_cnt_q - wd_staged_s - (WAW+1)'(wd_pop_s);
    end else begin
      wd_wr_d  = wd_wr_q + (WAW+1)'(wd_push_s);
      wd_cnt_d = wd_cnt_q + (WAW+1)'(wd_push_s) - (WAW+1)'(wd_pop_s);
    end
    if (wr_addr_s) begin
      wd_commit_d = wd_wr_d;
      stg_cnt_d   = 4'd0;
    end else if (wd_push_s && (stg_cnt_q != 4'hF)) begin
      wd_commit_d = wd_commit_q;
      stg_cnt_d   = stg_cnt_q + 4'd1;
    end else begin
      wd_commit_d = wd_commit_q;
      stg_cnt_d   = stg_cnt_q;
    end
  end

  // Command FSM: present the queue head, then stream the write line for write commands.
  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    cmd_pop_s       = 1'b0;
    wd_pop_s        = 1'b0;
    tag_push_s      = 1'b0;
    mem_cmd_valid_s = 1'b0;
    case (state_q)
      CMD_IDLE: begin
        if (cmd_cnt_q != '0) begin
          state_d = CMD_ISSUE;
        end else begin
          state_d = CMD_IDLE;
        end
      end
      CMD_ISSUE: begin
        // A read needs a free return tag before it may be offered.
        mem_cmd_valid_s = cmd_head_s[32] || (tag_cnt_q != CMD_FULL);
        if (mem_cmd_valid_s && memCmdReady) begin
          cmd_pop_s = 1'b1;
          if (cmd_head_s[32]) begin
            state_d = CMD_WDATA;
            wcnt_d  = 3'd0;
          end else begin
            tag_push_s = 1'b1;
            state_d    = CMD_IDLE;
          end
        end else begin
          state_d = CMD_ISSUE;
        end
      end
      CMD_WDATA: begin
        if (memWDataReady && (wd_cnt_q != '0)) begin
          wd_pop_s = 1'b1;
          wcnt_d   = wcnt_q + 3'd1;
          if (wcnt_q == 3'd7) begin
            state_d = CMD_IDLE;
          end else begin
            state_d = CMD_WDATA;
          end
        end else begin
          state_d = CMD_WDATA;
        end
      end
      default: begin
        state_d = CMD_IDLE;
      end
    endcase
  end

  // Read return: tag each word with the oldest outstanding requester, retire the tag after 8 words.
  always_comb begin
    rd_return_d = rd_return_q;
    rd_dest_d   = NULL_DEST;
    rcnt_d      = rcnt_q;
    tag_pop_s   = 1'b0;
    rd_orphan_s = 1'b0;
    if (memRDataValid) begin
      if (tag_cnt_q != '0) begin
        rd_return_d = memRData;
        rd_dest_d   = tag_mem_q[tag_rd_q];
        rcnt_d      = rcnt_q + 3'd1;
        tag_pop_s   = (rcnt_q == 3'd7);
      end else begin
        rd_orphan_s = 1'b1;
      end
    end else begin
      rd_orphan_s = 1'b0;
    end
  end

  // Sticky error: malformed write line, any dropped push, or an untagged read word.
  always_comb begin
    proto_err_d = proto_err_q | (slot_wdata_s & ~wd_push_s) | (slot_addr_s & ~cmd_push_s) | rd_orphan_s;
  end

  // Control state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CMD_IDLE;  ring_out_q <= 32'd0;  slot_type_out_q <= SLOT_NULL;
      source_out_q <= 4'd0; rd_return_q <= 32'd0; rd_dest_q <= NULL_DEST;
      proto_err_q <= 1'b0;  stg_cnt_q <= 4'd0;    wcnt_q <= 3'd0;  rcnt_q <= 3'd0;
      cmd_wr_q <= '0; cmd_rd_q <= '0; cmd_cnt_q <= '0;
      tag_wr_q <= '0; tag_rd_q <= '0; tag_cnt_q <= '0;
      wd_wr_q <= '0;  wd_rd_q <= '0;  wd_cnt_q <= '0;  wd_commit_q <= '0;
    end else begin
      state_q <= state_d;  ring_out_q <= ring_out_d;  slot_type_out_q <= slot_type_out_d;
      source_out_q <= source_out_d; rd_return_q <= rd_return_d; rd_dest_q <= rd_dest_d;
      proto_err_q <= proto_err_d;   stg_cnt_q <= stg_cnt_d;     wcnt_q <= wcnt_d; rcnt_q <= rcnt_d;
      cmd_wr_q <= cmd_wr_d; cmd_rd_q <= cmd_rd_d; cmd_cnt_q <= cmd_cnt_d;
      tag_wr_q <= tag_wr_d; tag_rd_q <= tag_rd_d; tag_cnt_q <= tag_cnt_d;
      wd_wr_q <= wd_wr_d;   wd_rd_q <= wd_rd_d;   wd_cnt_q <= wd_cnt_d; wd_commit_q <= wd_commit_d;
    end
  end

  // FIFO storage; contents only matter where the counts say they are valid.
  always_ff @(posedge clock) begin
    if (cmd_push_s) cmd_mem_q[cmd_wr_q] <= {~addr_read_s, RingIn[27:0], SourceIn};
    if (wd_push_s)  wd_mem_q[wd_wr_q[WAW-1:0]] <= RingIn;
    if (tag_push_s) tag_mem_q[tag_wr_q] <= cmd_head_s[3:0];
  end

  assign RingOut       = ring_out_q;
  assign SlotTypeOut   = slot_type_out_q;
  assign SourceOut     = source_out_q;
  assign RDreturn      = rd_return_q;
  assign RDdest        = rd_dest_q;
  assign memCmdValid   = mem_cmd_valid_s;
  assign memCmdWrite   = cmd_head_s[32];
  assign memAddr       = cmd_head_s[31:4];
  assign memWData      = wd_mem_q[wd_rd_q];
  assign memWDataValid = (state_q == CMD_WDATA);
  assign protoErr      = proto_err_q;
endmodule

// File: tb/tb_mem_ring_stop.sv
// tb_mem_ring_stop: directed bench for mem_ring_stop with a small line-burst memory responder.
module tb_mem_ring_stop;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] RingIn, RingOut, RDreturn, memWData, memRData;
  logic [3:0]  SlotTypeIn, SourceIn, SlotTypeOut, SourceOut, RDdest;
  logic        memCmdValid, memCmdReady, memCmdWrite, memWDataValid, memWDataReady;
  logic        memRDataValid, protoErr;
  logic [27:0] memAddr;

  int checks = 0;
  int errors = 0;
  logic [28:0] cmd_log[$];   // {write, line address}
  logic [31:0] wd_log[$];
  logic [35:0] ret_log[$];   // {RDdest, RDreturn}
  logic [27:0] rd_pend[$];
  int          rd_due[$];
  logic        gap_mode = 1'b0;

  always #5 clock = ~clock;

  mem_ring_stop #(.CMD_DEPTH(16), .WLINES(16), .NULL_DEST(4'd0)) dut (
    .clock(clock), .reset(reset), .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .RDreturn(RDreturn), .RDdest(RDdest), .memCmdValid(memCmdValid), .memCmdReady(memCmdReady),
    .memCmdWrite(memCmdWrite), .memAddr(memAddr), .memWData(memWData), .memWDataValid(memWDataValid),
    .memWDataReady(memWDataReady), .memRData(memRData), .memRDataValid(memRDataValid), .protoErr(protoErr)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
    SlotTypeIn = t; RingIn = d; SourceIn = s;
    step(1);
    SlotTypeIn = 4'd7; RingIn = 32'd0; SourceIn = 4'd0;
  endtask

  task automatic clear_logs();
    cmd_log.delete(); wd_log.delete(); ret_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    clear_logs();
  endtask

  task automatic wait_rets(input string tag, input int n, input int budget);
    int k = 0;
    while ((ret_log.size() < n) && (k < budget)) begin
      step(1);
      k++;
    end
    step(4);
    check_eq(tag, 64'(ret_log.size()), 64'(n));
  endtask

  // Memory responder: logs handshakes seen before each rising edge, returns 8 words per read after 5 cycles.
  initial begin : mem_model
    int          cyc;
    int          beat;
    logic        active;
    logic        gap_tog;
    logic [27:0] cur_addr;
    cyc = 0; beat = 0; active = 1'b0; gap_tog = 1'b0; cur_addr = 28'd0;
    memRData = 32'd0; memRDataValid = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        rd_pend.delete(); rd_due.delete(); active = 1'b0; memRDataValid = 1'b0;
      end else begin
        if (memCmdValid && memCmdReady) begin
          cmd_log.push_back({memCmdWrite, memAddr});
          if (!memCmdWrite) begin
            rd_pend.push_back(memAddr);
            rd_due.push_back(cyc + 5);
          end
        end
        if (memWDataValid && memWDataReady) wd_log.push_back(memWData);
        if (RDdest != 4'd0) ret_log.push_back({RDdest, RDreturn});
        if (!active && (rd_pend.size() > 0)) begin
          if (rd_due[0] <= cyc) begin
            active = 1'b1; cur_addr = rd_pend.pop_front(); void'(rd_due.pop_front()); beat = 0;
          end
        end
        gap_tog = ~gap_tog;
        if (active && !(gap_mode && gap_tog)) begin
          memRData = {cur_addr, 4'(beat)}; memRDataValid = 1'b1;
          beat++;
          if (beat == 8) active = 1'b0;
        end else begin
          memRDataValid = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [3:0]  bp_src [3];
    logic [27:0] bp_addr [3];
    logic [3:0]  pt_type [3];
    logic [31:0] pt_data [3];
    logic [3:0]  pt_src [3];
    int k;
    bp_src  = '{4'd1, 4'd2, 4'd4};
    bp_addr = '{28'h60, 28'h70, 28'h80};
    pt_type = '{4'd1, 4'd4, 4'd2};
    pt_data = '{32'h1234_5678, 32'hCAFE_F00D, 32'h8000_0000};
    pt_src  = '{4'd2, 4'd9, 4'd6};
    RingIn = 32'd0; SlotTypeIn = 4'd7; SourceIn = 4'd0;
    memCmdReady = 1'b1; memWDataReady = 1'b1;
    reset = 1'b0;
    #1 reset = 1'b1;
    step(2);
    // Reset values.
    check_eq("rst_ringout", RingOut, 32'd0);
    check_eq("rst_slottype", SlotTypeOut, 4'd7);
    check_eq("rst_source", SourceOut, 4'd0);
    check_eq("rst_rdreturn", RDreturn, 32'd0);
    check_eq("rst_rddest", RDdest, 4'd0);
    check_eq("rst_cmdvalid", memCmdValid, 1'b0);
    check_eq("rst_wdvalid", memWDataValid, 1'b0);
    check_eq("rst_protoerr", protoErr, 1'b0);
    reset = 1'b0;
    step(1);
    clear_logs();

    // Read miss from core 3.
    send(4'd2, 32'h1000_0ABC, 4'd3);
    check_eq("rm_null_type", SlotTypeOut, 4'd7);
    check_eq("rm_null_data", RingOut, 32'd0);
    wait_rets("rm_count", 8, 60);
    check_eq("rm_ncmd", 64'(cmd_log.size()), 64'd1);
    check_eq("rm_cmd", cmd_log[0], {1'b0, 28'h0000ABC});
    for (int i = 0; i < 8; i++) check_eq("rm_ret", ret_log[i], {4'd3, 28'h0000ABC, 4'(i)});
    check_eq("rm_idle_dest", RDdest, 4'd0);
    check_eq("rm_protoerr", protoErr, 1'b0);

    // Dirty miss: write-back of line 0x10 then read of line 0x20, both from core 5.
    clear_logs();
    for (int i = 0; i < 8; i++) send(4'd3, 32'hD000_0000 + 32'(i), 4'd5);
    check_eq("dm_wd_null", SlotTypeOut, 4'd7);
    send(4'd2, 32'h0000_0010, 4'd5);
    send(4'd2, 32'h1000_0020, 4'd5);
    wait_rets("dm_count", 8, 100);
    check_eq("dm_ncmd", 64'(cmd_log.size()), 64'd2);
    check_eq("dm_cmd0", cmd_log[0], {1'b1, 28'h10});
    check_eq("dm_cmd1", cmd_log[1], {1'b0, 28'h20});
    check_eq("dm_nwd", 64'(wd_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) check_eq("dm_wdata", wd_log[i], 32'hD000_0000 + 32'(i));
    check_eq("dm_ret0", ret_log[0], {4'd5, 28'h20, 4'd0});
    check_eq("dm_ret7", ret_log[7], {4'd5, 28'h20, 4'd7});

    // Pass-through of Token, ReadData and a non-memory Address slot.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      SlotTypeIn = pt_type[i]; RingIn = pt_data[i]; SourceIn = pt_src[i];
      #1;
      check_eq("pt_not_early", SlotTypeOut, 4'd7);
      step(1);
      check_eq("pt_data", RingOut, pt_data[i]);
      check_eq("pt_type", SlotTypeOut, pt_type[i]);
      check_eq("pt_src", SourceOut, pt_src[i]);
      SlotTypeIn = 4'd7; RingIn = 32'd0; SourceIn = 4'd0;
      step(1);
    end
    step(10);
    check_eq("pt_nocmd", 64'(cmd_log.size()), 64'd0);

    // Short write line: error, no command, staged words discarded.
    do_reset();
    for (int i = 0; i < 5; i++) send(4'd3, 32'hBAD0_0000 + 32'(i), 4'd7);
    send(4'd2, 32'h0000_0030, 4'd7);
    step(2);
    check_eq("pe_err", protoErr, 1'b1);
    step(10);
    check_eq("pe_nocmd", 64'(cmd_log.size()), 64'd0);
    for (int i = 0; i < 8; i++) send(4'd3, 32'hE000_0000 + 32'(i), 4'd2);
    send(4'd2, 32'h0000_0050, 4'd2);
    send(4'd2, 32'h1000_0040, 4'd2);
    wait_rets("pe_count", 8, 100);
    check_eq("pe_ncmd", 64'(cmd_log.size()), 64'd2);
    check_eq("pe_cmd0", cmd_log[0], {1'b1, 28'h50});
    check_eq("pe_cmd1", cmd_log[1], {1'b0, 28'h40});
    check_eq("pe_nwd", 64'(wd_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) check_eq("pe_wdata", wd_log[i], 32'hE000_0000 + 32'(i));
    check_eq("pe_ret0", ret_log[0], {4'd2, 28'h40, 4'd0});
    check_eq("pe_sticky", protoErr, 1'b1);

    // Backpressure with three queued reads, then gapped returns.
    do_reset();
    memCmdReady = 1'b0;
    for (int i = 0; i < 3; i++) send(4'd2, {4'h1, bp_addr[i]}, bp_src[i]);
    step(20);
    check_eq("bp_valid", memCmdValid, 1'b1);
    check_eq("bp_head", memAddr, 28'h60);
    check_eq("bp_nocmd", 64'(cmd_log.size()), 64'd0);
    check_eq("bp_noerr", protoErr, 1'b0);
    memCmdReady = 1'b1;
    gap_mode = 1'b1;
    wait_rets("bp_count", 24, 300);
    gap_mode = 1'b0;
    for (int i = 0; i < 24; i++) check_eq("bp_ret", ret_log[i], {bp_src[i/8], bp_addr[i/8], 4'(i%8)});
    check_eq("bp_noerr_end", protoErr, 1'b0);

    // Command FIFO overflow: 17 reads with memory stalled, the 17th is dropped.
    do_reset();
    memCmdReady = 1'b0;
    for (int i = 0; i < 17; i++) send(4'd2, 32'h1000_0100 + 32'(i), 4'd1);
    step(1);
    check_eq("ov_err", protoErr, 1'b1);
    memCmdReady = 1'b1;
    wait_rets("ov_count", 128, 1500);
    check_eq("ov_ncmd", 64'(cmd_log.size()), 64'd16);
    for (int i = 0; i < 16; i++) check_eq("ov_cmd", cmd_log[i], {1'b0, 28'h100 + 28'(i)});
    check_eq("ov_last", ret_log[127], {4'd1, 28'h10F, 4'd7});

    // Reset asserted while a write line is being streamed.
    do_reset();
    memWDataReady = 1'b0;
    for (int i = 0; i < 8; i++) send(4'd3, 32'hA000_0000 + 32'(i), 4'd3);
    send(4'd2, 32'h0000_0090, 4'd3);
    SlotTypeIn = 4'd1; RingIn = 32'h0000_0055; SourceIn = 4'd9;
    k = 0;
    while (!memWDataValid && (k < 20)) begin
      step(1);
      k++;
    end
    check_eq("rw_wdata_phase", memWDataValid, 1'b1);
    check_eq("rw_token", RingOut, 32'h0000_0055);
    #2 reset = 1'b1;
    #1;
    check_eq("rw_wdvalid", memWDataValid, 1'b0);
    check_eq("rw_cmdvalid", memCmdValid, 1'b0);
    check_eq("rw_ringout", RingOut, 32'd0);
    check_eq("rw_slottype", SlotTypeOut, 4'd7);
    check_eq("rw_source", SourceOut, 4'd0);
    check_eq("rw_rddest", RDdest, 4'd0);
    check_eq("rw_rdreturn", RDreturn, 32'd0);
    SlotTypeIn = 4'd7; RingIn = 32'd0; SourceIn = 4'd0;
    step(2);
    reset = 1'b0;
    memWDataReady = 1'b1;
    step(1);
    clear_logs();
    send(4'd2, 32'h1000_00A0, 4'd4);
    wait_rets("rw_count", 8, 60);
    check_eq("rw_ncmd", 64'(cmd_log.size()), 64'd1);
    check_eq("rw_cmd", cmd_log[0], {1'b0, 28'hA0});
    check_eq("rw_nwd", 64'(wd_log.size()), 64'd0);
    check_eq("rw_ret0", ret_log[0], {4'd4, 28'hA0, 4'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
